camera_capture_ctrl: RTL and testbench
======================================

Name: camera_capture_ctrl

Overview:
- Sequences the 8-bit camera source: drives its enable for exactly one frame of FRAME_LEN bytes at a time.
- Forces the enable low between frames so the camera's internal byte pointer restarts at 0, keeping frames byte-aligned.
- Buffers received bytes in an internal first-word-fall-through FIFO and hands them to a downstream consumer over a valid/ready handshake.
- Supports single-shot and continuous capture, with a programmable inter-frame gap.

Parameters:
- FRAME_LEN, 12, bytes per frame; must equal the camera sequence length. Range 1..255.
- GAP_CYCLES, 4, idle cycles with camera_en low between frames in continuous mode. Range 1..255.
- FIFO_DEPTH, 16, byte FIFO entries. Power of two, and must be >= FRAME_LEN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin capture; sampled only in IDLE.
- continuous  in  1  1 = after GAP, start the next frame; 0 = return to IDLE. Sampled on the last GAP cycle.
- camera_en  out  1  enable to the camera.
- cam_valid  in  1  camera data_valid.
- cam_data  in  8  camera data_out.
- out_valid  out  1  FIFO not empty.
- out_data  out  8  FIFO head byte (fall-through).
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse when the last byte of a frame is written.
- frame_count  out  8  completed frames; wraps 255 -> 0.
- byte_count  out  8  bytes written in the current frame.
- overflow  out  1  sticky; set when a byte is dropped because the FIFO is full.

Behaviour:
- Reset (synchronous, rst high at an edge):
  - state = IDLE; camera_en = 0; FIFO emptied, so out_valid = 0 and out_data = 0.
  - busy = 0, frame_done = 0, frame_count = 0, byte_count = 0, overflow = 0.
  - Reset mid-frame: camera_en is low from the following cycle; partial-frame bytes are discarded.
- camera_en = (state == CAPTURE), decoded from the state register with no combinational input path.
- Camera latency is 1 cycle: enable high at cycle t gives cam_valid/cam_data at t+1.
- FSM:
  - IDLE: start=1 -> WAIT_SPACE. Also clears overflow and byte_count. start is ignored in every other state.
  - WAIT_SPACE: free entries >= FRAME_LEN -> CAPTURE; otherwise stay. This guarantees a full frame always fits.
  - CAPTURE: held exactly FRAME_LEN cycles (down-counter) -> FLUSH.
  - FLUSH: exactly 1 cycle, camera_en low; receives the final byte -> GAP.
  - GAP: exactly GAP_CYCLES cycles. On the last cycle: continuous=1 -> WAIT_SPACE, else -> IDLE.
- Byte capture:
  - A byte is accepted only when cam_valid=1 and state is CAPTURE or FLUSH.
  - cam_valid in any other state is ignored and does not affect counters.
  - Each accepted byte is pushed to the FIFO and increments byte_count.
  - byte_count resets to 0 on entry to CAPTURE.
- frame_done:
  - Pulses in the cycle after the write that brings byte_count to FRAME_LEN; frame_count increments in the same cycle.
  - A frame that delivers fewer bytes than FRAME_LEN gives no pulse and no increment.
- FIFO:
  - Push is accepted if not full, or if full with a pop in the same cycle.
  - Push and pop in the same cycle leave occupancy unchanged.
  - A push while full with no pop drops the byte and sets overflow (sticky until the next IDLE start, or rst).
  - out_data is held stable while out_valid=1 and out_ready=0.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter range is 0..FIFO_DEPTH.
- Frame alignment: camera_en is low for at least 1 + GAP_CYCLES cycles between frames, so each frame starts at camera byte 0.

Test Plan:
- Single shot: FRAME_LEN=12, out_ready=1, pulse start -> camera_en high for 12 cycles, starting 2 cycles after the start edge; out_data stream BC 27 81 FF CE 1F E0 A9 38 2B D4 11; one frame_done; frame_count=1; busy falls after GAP; final state IDLE.
- Continuous, 3 frames: continuous=1 then dropped during frame 3 -> camera_en low exactly 5 cycles between frames (FLUSH + 4 GAP); each frame starts with BC; frame_count=3; ends in IDLE.
- Backpressure: FIFO_DEPTH=16, out_ready=0, continuous=1 -> frame 1 completes and 12 bytes are held; controller stalls in WAIT_SPACE with camera_en=0 (4 free < 12). Raise out_ready -> once 12 entries are free, frame 2 starts; overflow stays 0; no byte lost or reordered.
- Simultaneous push/pop at full: fill to 16, then pop and push in the same cycle -> occupancy stays 16, no overflow. Force a stray push at full without pop (debug injection in FLUSH) -> byte dropped, overflow=1 and remains 1 until the next start from IDLE.
- Reset mid-frame: assert rst on the 6th CAPTURE cycle -> next cycle camera_en=0, out_valid=0, counters 0. A new start yields a frame beginning with BC.
- Stray input: cam_valid=1 with data 55 while IDLE -> no FIFO write, byte_count unchanged, out_valid stays 0.

Source files
------------

// File: rtl/camera_capture_ctrl.sv
// Camera capture sequencer: gates the camera enable one frame at a time and
// buffers captured bytes in a first-word-fall-through FIFO for a valid/ready consumer.
module camera_capture_ctrl #(
  parameter int FRAME_LEN  = 12,
  parameter int GAP_CYCLES = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  output logic       camera_en,
  input  logic       cam_valid,
  input  logic [7:0] cam_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count,
  output logic [7:0] byte_count,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SPACE,
    CAPTURE,
    FLUSH,
    GAP
  } state_t;

  state_t state, state_next;

  logic [7:0]    cnt;
  logic          cnt_zero;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          full, space_ok;
  logic          push_req, push_ok, pop;
  logic          cap_entry, idle_start;

  assign cnt_zero   = (cnt == '0);
  assign full       = (occ == (AW+1)'(FIFO_DEPTH));
  assign space_ok   = (((AW+1)'(FIFO_DEPTH) - occ) >= (AW+1)'(FRAME_LEN));
  assign idle_start = (state == IDLE) && start;
  assign cap_entry  = (state_next == CAPTURE) && (state != CAPTURE);

  assign push_req   = cam_valid && ((state == CAPTURE) || (state == FLUSH));
  assign pop        = out_valid && out_ready;
  assign push_ok    = push_req && (!full || pop);

  assign out_valid  = (occ != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    camera_en  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = WAIT_SPACE;
      end
      WAIT_SPACE: if (space_ok) state_next = CAPTURE;
      CAPTURE: begin
        camera_en = 1'b1;
        if (cnt_zero) state_next = FLUSH;
      end
      FLUSH: state_next = GAP;
      GAP: begin
        // The space check is folded into the last gap cycle so back-to-back
        // frames see only FLUSH + GAP_CYCLES of enable-low time.
        if (cnt_zero) begin
          if (!continuous)   state_next = IDLE;
          else if (space_ok) state_next = CAPTURE;
          else               state_next = WAIT_SPACE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shared down-counter: CAPTURE length, then GAP length.
  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (cap_entry)     cnt <= 8'(FRAME_LEN - 1);
    else if (state == FLUSH) cnt <= 8'(GAP_CYCLES - 1);
    else if (!cnt_zero)     cnt <= cnt - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= cam_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_count  <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (idle_start || cap_entry) begin
        byte_count <= '0;
      end else if (push_req) begin
        byte_count <= byte_count + 8'd1;
        if (byte_count == 8'(FRAME_LEN - 1)) begin
          frame_done  <= 1'b1;
          frame_count <= frame_count + 8'd1;
        end
      end
      if (idle_start)              overflow <= 1'b0;
      else if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Directed self-checking bench for camera_capture_ctrl with a 1-cycle-latency camera model.
module tb_camera_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic       camera_en;
  logic       cam_valid = 1'b0;
  logic [7:0] cam_data = '0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       frame_done;
  logic [7:0] frame_count;
  logic [7:0] byte_count;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] seq [12] = '{8'hBC, 8'h27, 8'h81, 8'hFF, 8'hCE, 8'h1F,
                           8'hE0, 8'hA9, 8'h38, 8'h2B, 8'hD4, 8'h11};

  logic       stray  = 1'b0;
  logic       inject = 1'b0;
  logic       prev_en = 1'b0;
  int         ptr = 0;
  logic [7:0] rx [$];
  logic [7:0] exp_q [$];
  int         fd_cnt = 0;

  camera_capture_ctrl #(
    .FRAME_LEN (12),
    .GAP_CYCLES(4),
    .FIFO_DEPTH(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .continuous (continuous),
    .camera_en  (camera_en),
    .cam_valid  (cam_valid),
    .cam_data   (cam_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .byte_count (byte_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Camera: enable seen in cycle t produces a byte in cycle t+1; pointer restarts while disabled.
  always @(negedge clk) begin
    if (stray) begin
      cam_valid = 1'b1;
      cam_data  = 8'h55;
    end else if (prev_en) begin
      cam_valid = 1'b1;
      cam_data  = seq[ptr];
      ptr       = (ptr == 11) ? 0 : ptr + 1;
    end else if (inject && camera_en) begin
      cam_valid = 1'b1;
      cam_data  = 8'h5A;
    end else begin
      cam_valid = 1'b0;
      cam_data  = 8'h00;
    end
    if (!prev_en) ptr = 0;
    prev_en = camera_en;
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) rx.push_back(out_data);
    if (!rst && frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; continuous = 1'b0; out_ready = 1'b0;
    inject = 1'b0; stray = 1'b0;
    tick(); tick();
    rst = 1'b0;
    rx.delete();
    fd_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (!camera_en && n < 100) begin tick(); n++; end
    check(tag, camera_en, 1'b1);
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (camera_en == lvl && n < 100) begin tick(); n++; end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    check(tag, busy, 1'b0);
  endtask

  task automatic add_seq(input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back(seq[i]);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, rx.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx.size(); i++) check(tag, rx[i], exp_q[i]);
  endtask

  initial begin
    int n;

    // Reset values and stray camera input while idle
    do_reset();
    check("rst_en", camera_en, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_counts", {frame_done, overflow, frame_count, byte_count}, '0);
    stray = 1'b1;
    repeat (3) tick();
    stray = 1'b0;
    tick();
    check("stray_valid", out_valid, 1'b0);
    check("stray_bytes", byte_count, 8'd0);

    // Single shot
    out_ready = 1'b1;
    pulse_start();
    check("ss_busy", busy, 1'b1);
    check("ss_wait_en", camera_en, 1'b0);
    tick();
    check("ss_en_on", camera_en, 1'b1);
    run_len(1'b1, n);
    check("ss_en_len", n, 12);
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    check("ss_tail_len", n, 5);
    repeat (3) tick();
    exp_q.delete();
    add_seq(12);
    check_stream("ss_data");
    check("ss_fd", fd_cnt, 1);
    check("ss_fcnt", frame_count, 8'd1);
    check("ss_bcnt", byte_count, 8'd12);

    // Continuous, three frames
    do_reset();
    out_ready = 1'b1;
    continuous = 1'b1;
    pulse_start();
    wait_en("ct_first_en");
    for (int f = 0; f < 3; f++) begin
      if (f == 2) continuous = 1'b0;
      run_len(1'b1, n);
      check("ct_en_len", n, 12);
      if (f < 2) begin
        run_len(1'b0, n);
        check("ct_gap_len", n, 5);
      end
    end
    wait_idle("ct_idle");
    repeat (3) tick();
    exp_q.delete();
    add_seq(12); add_seq(12); add_seq(12);
    check_stream("ct_data");
    check("ct_fd", fd_cnt, 3);
    check("ct_fcnt", frame_count, 8'd3);

    // Backpressure stall in WAIT_SPACE
    do_reset();
    continuous = 1'b1;
    pulse_start();
    wait_en("bp_first_en");
    run_len(1'b1, n);
    check("bp_en_len", n, 12);
    n = 0;
    repeat (20) begin tick(); if (camera_en) n++; end
    check("bp_stall_en", n, 0);
    check("bp_stall_busy", busy, 1'b1);
    check("bp_head", {out_valid, out_data}, {1'b1, 8'hBC});
    check("bp_bcnt", byte_count, 8'd12);
    continuous = 1'b0;
    out_ready = 1'b1;
    run_len(1'b0, n);
    check("bp_resume_delay", n, 9);
    run_len(1'b1, n);
    check("bp_en2_len", n, 12);
    wait_idle("bp_idle");
    repeat (20) tick();
    exp_q.delete();
    add_seq(12); add_seq(12);
    check_stream("bp_data");
    check("bp_ovf", overflow, 1'b0);
    check("bp_fcnt", frame_count, 8'd2);

    // FIFO full: push+pop at full, then a dropped push
    do_reset();
    pulse_start();
    wait_idle("ff_f1_idle");
    out_ready = 1'b1;
    repeat (8) tick();
    out_ready = 1'b0;
    inject = 1'b1;
    pulse_start();
    wait_en("ff_a_en");
    run_len(1'b1, n);
    check("ff_a_en_len", n, 12);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ff_pushpop_ovf", overflow, 1'b0);
    wait_idle("ff_a_idle");
    out_ready = 1'b1;
    repeat (12) tick();
    out_ready = 1'b0;
    pulse_start();
    wait_en("ff_b_en");
    run_len(1'b1, n);
    check("ff_pre_drop_ovf", overflow, 1'b0);
    tick();
    check("ff_drop_ovf", overflow, 1'b1);
    wait_idle("ff_b_idle");
    inject = 1'b0;
    repeat (3) tick();
    check("ff_ovf_sticky", overflow, 1'b1);
    out_ready = 1'b1;
    repeat (20) tick();
    check("ff_drained", out_valid, 1'b0);
    exp_q.delete();
    add_seq(12); exp_q.push_back(8'h5A);
    add_seq(12); exp_q.push_back(8'h5A);
    add_seq(11);
    check_stream("ff_data");
    pulse_start();
    check("ff_ovf_clear", overflow, 1'b0);
    wait_idle("ff_c_idle");

    // Reset mid-frame
    do_reset();
    pulse_start();
    wait_en("mr_en");
    repeat (5) tick();
    check("mr_pre_bcnt", byte_count, 8'd4);
    check("mr_pre_valid", out_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_en", camera_en, 1'b0);
    check("mr_valid", out_valid, 1'b0);
    check("mr_counts", {busy, frame_count, byte_count}, '0);
    rx.delete();
    tick();
    out_ready = 1'b1;
    pulse_start();
    wait_idle("mr_idle");
    repeat (3) tick();
    exp_q.delete();
    add_seq(12);
    check_stream("mr_data");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
